// File: rtl/decode_queue.sv
// decode_queue: registered, buffered MIPS instruction decoder.
//
// Each raw instruction word accepted from fetch is decoded to a 6-bit ID
// (63 means illegal) and stored in a DEPTH-entry FIFO together with its
// operand fields and PC. The head entry is presented to execute as a
// first-word fall-through output.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous discard of all buffered entries
//   in_valid/ready    fetch handshake; in_inst, in_pc carry the instruction
//   out_valid/ready   execute handshake for the head entry
//   out_id            decoded ID (63 = illegal or empty), out_illegal flag
//   out_rs/rt/rd/sa   fields [25:21] [20:16] [15:11] [10:6]
//   out_imm           [15:0], out_target [25:0], out_pc head PC
//   count             occupied entries
//   illegal_cnt       saturating count of illegal instructions accepted
//
// Build option: define DECQ_STRICT_EN to also require reserved fields to be
// zero (or fixed) before an instruction is considered legal.

module decode_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_inst,
   input  logic [PC_W-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [5:0]               out_id,
   output logic                     out_illegal,
   output logic [4:0]               out_rs,
   output logic [4:0]               out_rt,
   output logic [4:0]               out_rd,
   output logic [4:0]               out_sa,
   output logic [15:0]              out_imm,
   output logic [25:0]              out_target,
   output logic [PC_W-1:0]          out_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               illegal_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [5:0] ID_ILL = 6'd63;

   // Every operand field lives inside bits [25:0], so only those are stored.
   typedef struct packed {
      logic [5:0]      id;
      logic            ill;
      logic [25:0]     tgt;
      logic [PC_W-1:0] pc;
   } entry_t;

   // ---------------------------------------------------------------- decode
   logic [5:0] op, fn, base_id, dec_id;
   logic [4:0] rs;
   logic       dec_ill;

   assign op = in_inst[31:26];
   assign fn = in_inst[5:0];
   assign rs = in_inst[25:21];

   always_comb begin
      base_id = ID_ILL;
      case (op)
         6'h00: begin
            case (fn)
               6'h20: base_id = 6'd0;
               6'h21: base_id = 6'd1;
               6'h22: base_id = 6'd2;
               6'h23: base_id = 6'd3;
               6'h24: base_id = 6'd4;
               6'h25: base_id = 6'd5;
               6'h26: base_id = 6'd6;
               6'h27: base_id = 6'd7;
               6'h2A: base_id = 6'd8;
               6'h2B: base_id = 6'd9;
               6'h00: base_id = 6'd10;
               6'h02: base_id = 6'd11;
               6'h03: base_id = 6'd12;
               6'h04: base_id = 6'd13;
               6'h06: base_id = 6'd14;
               6'h07: base_id = 6'd15;
               6'h08: base_id = 6'd16;
               6'h1B: base_id = 6'd32;
               6'h09: base_id = 6'd34;
               6'h10: base_id = 6'd42;
               6'h12: base_id = 6'd43;
               6'h11: base_id = 6'd45;
               6'h13: base_id = 6'd46;
               6'h19: base_id = 6'd48;
               6'h0C: base_id = 6'd49;
               6'h34: base_id = 6'd50;
               6'h0D: base_id = 6'd52;
               6'h1A: base_id = 6'd53;
               default: base_id = ID_ILL;
            endcase
         end
         6'h08: base_id = 6'd17;
         6'h09: base_id = 6'd18;
         6'h0C: base_id = 6'd19;
         6'h0D: base_id = 6'd20;
         6'h0E: base_id = 6'd21;
         6'h23: base_id = 6'd22;
         6'h2B: base_id = 6'd23;
         6'h04: base_id = 6'd24;
         6'h05: base_id = 6'd25;
         6'h0A: base_id = 6'd26;
         6'h0B: base_id = 6'd27;
         6'h0F: base_id = 6'd28;
         6'h02: base_id = 6'd29;
         6'h03: base_id = 6'd30;
         6'h1C: begin
            if (fn == 6'h20)      base_id = 6'd31;
            else if (fn == 6'h02) base_id = 6'd47;
         end
         6'h10: begin
            // COP0 group: ERET by func, MFC0/MTC0 distinguished by rs
            if (fn == 6'h18) base_id = 6'd33;
            else if (fn == 6'h00) begin
               if (rs == 5'h00)      base_id = 6'd41;
               else if (rs == 5'h04) base_id = 6'd44;
            end
         end
         6'h20: base_id = 6'd35;
         6'h24: base_id = 6'd36;
         6'h25: base_id = 6'd37;
         6'h28: base_id = 6'd38;
         6'h29: base_id = 6'd39;
         6'h21: base_id = 6'd40;
         6'h01: base_id = 6'd51;
         default: base_id = ID_ILL;
      endcase
   end

`ifdef DECQ_STRICT_EN
   logic [4:0] rt, rd, sa;
   logic       strict_ok;

   assign rt = in_inst[20:16];
   assign rd = in_inst[15:11];
   assign sa = in_inst[10:6];

   // Reserved-field checks layered on top of the op/func match.
   always_comb begin
      strict_ok = 1'b1;
      case (base_id)
         6'd10, 6'd11, 6'd12: strict_ok = (rs == 5'd0);
         6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9,
         6'd13, 6'd14, 6'd15: strict_ok = (sa == 5'd0);
         6'd16:               strict_ok = (rt == 5'd0) && (rd == 5'd0) && (sa == 5'd0);
         6'd33:               strict_ok = (in_inst == 32'h42000018);
         6'd41, 6'd44:        strict_ok = (in_inst[10:3] == 8'd0);
         6'd51:               strict_ok = (rt == 5'd1);
         6'd42, 6'd43:        strict_ok = (rs == 5'd0) && (rt == 5'd0) && (sa == 5'd0);
         6'd45, 6'd46:        strict_ok = (rt == 5'd0) && (rd == 5'd0) && (sa == 5'd0);
         default:             strict_ok = 1'b1;
      endcase
   end

   assign dec_id = strict_ok ? base_id : ID_ILL;
`else
   assign dec_id = base_id;
`endif

   assign dec_ill = (dec_id == ID_ILL);

   // ---------------------------------------------------------------- FIFO
   entry_t        mem [DEPTH];
   entry_t        head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          push, pop, empty;

   assign empty    = (count == '0);
   assign in_ready = (count < FULL);
   assign push     = in_valid && in_ready && !flush;
   assign pop      = !empty && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{id: dec_id, ill: dec_ill, tgt: in_inst[25:0], pc: in_pc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         illegal_cnt <= '0;
      end else begin
         if (push && dec_ill && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- head
   // Storage is not reset, so every head output is masked while empty.
   assign head        = mem[rd_ptr];
   assign out_valid   = !empty;
   assign out_id      = empty ? ID_ILL : head.id;
   assign out_illegal = !empty && head.ill;
   assign out_target  = empty ? 26'd0 : head.tgt;
   assign out_rs      = out_target[25:21];
   assign out_rt      = out_target[20:16];
   assign out_rd      = out_target[15:11];
   assign out_sa      = out_target[10:6];
   assign out_imm     = out_target[15:0];
   assign out_pc      = empty ? '0 : head.pc;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH=4, PC_W=32).
module tb_decode_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_inst = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [5:0]  out_id;
   logic        out_illegal;
   logic [4:0]  out_rs, out_rt, out_rd, out_sa;
   logic [15:0] out_imm;
   logic [25:0] out_target;
   logic [31:0] out_pc;
   logic [2:0]  count;
   logic [7:0]  illegal_cnt;

   int checks = 0;
   int failures = 0;

   decode_queue #(.DEPTH(4), .PC_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_illegal(out_illegal), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_sa(out_sa), .out_imm(out_imm), .out_target(out_target), .out_pc(out_pc),
      .count(count), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] inst, input logic [31:0] pc);
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic dec_chk(input logic [31:0] inst, input logic [5:0] id, input logic ill);
      push(inst, 32'h1000);
      chk($sformatf("id_%08h", inst), {58'd0, out_id}, {58'd0, id});
      chk($sformatf("ill_%08h", inst), {63'd0, out_illegal}, {63'd0, ill});
      pop();
   endtask

   logic [31:0] fill_inst [5];
   logic [5:0]  fill_id   [5];

   initial begin
      fill_inst[0] = 32'h21080005; fill_id[0] = 6'd17;  // ADDI
      fill_inst[1] = 32'h8C000004; fill_id[1] = 6'd22;  // LW
      fill_inst[2] = 32'h08000010; fill_id[2] = 6'd29;  // J
      fill_inst[3] = 32'h0000000C; fill_id[3] = 6'd49;  // SYSCALL
      fill_inst[4] = 32'h10000000; fill_id[4] = 6'd24;  // BEQ, must be held off

      // reset state
      #2;
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_id", out_id, 63);
      chk("rst_illegal_cnt", illegal_cnt, 0);
      chk("rst_out_pc", out_pc, 0);
      step();
      rst = 1'b0;

      // single ADD
      push(32'h012A4020, 32'h00400000);
      chk("add_valid", out_valid, 1);
      chk("add_id", out_id, 0);
      chk("add_rs", out_rs, 9);
      chk("add_rt", out_rt, 10);
      chk("add_rd", out_rd, 8);
      chk("add_sa", out_sa, 0);
      chk("add_imm", out_imm, 16'h4020);
      chk("add_target", out_target, 26'h12A4020);
      chk("add_pc", out_pc, 32'h00400000);
      chk("add_count", count, 1);
      pop();
      chk("add_pop_count", count, 0);
      chk("add_pop_valid", out_valid, 0);
      chk("add_pop_id", out_id, 63);
      chk("add_pop_pc", out_pc, 0);

      // fill to DEPTH with execute stalled
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fill_ready_%0d", i), in_ready, 1);
         push(fill_inst[i], 32'h2000 + 32'(i * 4));
      end
      chk("full_count", count, 4);
      chk("full_ready", in_ready, 0);
      chk("full_head", out_id, fill_id[0]);
      push(fill_inst[4], 32'h2010);
      chk("held_count", count, 4);
      // pop while full: no bypass, the offered push is still refused
      in_valid = 1'b1;
      out_ready = 1'b1;
      chk("full_pop_ready", in_ready, 0);
      step();
      in_valid = 1'b0;
      chk("full_pop_count", count, 3);
      for (int i = 1; i < 4; i++) begin
         chk($sformatf("order_id_%0d", i), out_id, fill_id[i]);
         chk($sformatf("order_pc_%0d", i), out_pc, 32'h2000 + 32'(i * 4));
         step();
      end
      out_ready = 1'b0;
      chk("drain_count", count, 0);
      chk("drain_valid", out_valid, 0);

      // simultaneous push and pop
      push(32'h012A4020, 32'h3000);
      in_valid = 1'b1;
      in_inst = 32'h3C010001;  // LUI rt=1 imm=1
      in_pc = 32'h3004;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("pp_count", count, 1);
      chk("pp_id", out_id, 28);
      chk("pp_imm", out_imm, 1);
      chk("pp_rt", out_rt, 1);
      chk("pp_pc", out_pc, 32'h3004);
      step();
      out_ready = 1'b0;
      chk("pp_drain", count, 0);

      // illegal accounting and saturation
      push(32'hFC000000, 32'h4000);
      chk("ill_id", out_id, 63);
      chk("ill_flag", out_illegal, 1);
      chk("ill_valid", out_valid, 1);
      chk("ill_cnt1", illegal_cnt, 1);
      in_valid = 1'b1;
      out_ready = 1'b1;
      repeat (253) step();
      chk("ill_cnt254", illegal_cnt, 254);
      step();
      chk("ill_cnt255", illegal_cnt, 255);
      repeat (46) step();
      chk("ill_cnt_sat", illegal_cnt, 255);
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      chk("ill_drain", count, 0);

      // flush with a concurrent push and pop
      push(32'h012A4020, 32'h5000);
      push(32'h00000023, 32'h5004);
      chk("fl_pre_count", count, 2);
      flush = 1'b1;
      in_valid = 1'b1;
      in_inst = 32'h00000024;
      out_ready = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("fl_count", count, 0);
      chk("fl_valid", out_valid, 0);
      chk("fl_id", out_id, 63);
      chk("fl_ready", in_ready, 1);
      chk("fl_illegal_cnt", illegal_cnt, 255);
      push(32'h00000025, 32'h5008);
      chk("fl_after_id", out_id, 5);
      chk("fl_after_count", count, 1);
      chk("fl_after_pc", out_pc, 32'h5008);
      pop();

      // decode table spot checks
      dec_chk(32'h00000000, 6'd10, 1'b0);  // SLL all zero
      dec_chk(32'h70000020, 6'd31, 1'b0);  // CLZ
      dec_chk(32'h70000002, 6'd47, 1'b0);  // MUL
      dec_chk(32'h70000000, 6'd63, 1'b1);  // op 1C, unknown func
      dec_chk(32'h04010000, 6'd51, 1'b0);  // BGEZ
      dec_chk(32'h00000034, 6'd50, 1'b0);  // TEQ
      dec_chk(32'h0000001A, 6'd53, 1'b0);  // DIV
      dec_chk(32'h0000001B, 6'd32, 1'b0);  // DIVU
      dec_chk(32'h0000000D, 6'd52, 1'b0);  // BREAK
      dec_chk(32'h00000010, 6'd42, 1'b0);  // MFHI
      dec_chk(32'h00000013, 6'd46, 1'b0);  // MTLO
      dec_chk(32'hA0000000, 6'd38, 1'b0);  // SB
      dec_chk(32'h84000000, 6'd40, 1'b0);  // LH
      dec_chk(32'h40016000, 6'd41, 1'b0);  // MFC0
      dec_chk(32'h40816000, 6'd44, 1'b0);  // MTC0
      dec_chk(32'h40400000, 6'd63, 1'b1);  // COP0 rs=2
      dec_chk(32'h42000018, 6'd33, 1'b0);  // ERET
      dec_chk(32'h0C000000, 6'd30, 1'b0);  // JAL
`ifdef DECQ_STRICT_EN
      dec_chk(32'h00221080, 6'd63, 1'b1);  // SLL with rs=1
      dec_chk(32'h012A4060, 6'd63, 1'b1);  // ADD with sa=1
`else
      dec_chk(32'h00221080, 6'd10, 1'b0);
      dec_chk(32'h012A4060, 6'd0, 1'b0);
`endif

      // asynchronous reset mid-stream
      push(32'h012A4020, 32'h6000);
      push(32'h012A4020, 32'h6004);
      push(32'h012A4020, 32'h6008);
      chk("ar_pre_count", count, 3);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_count", count, 0);
      chk("ar_valid", out_valid, 0);
      chk("ar_id", out_id, 63);
      chk("ar_ready", in_ready, 1);
      chk("ar_illegal_cnt", illegal_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      push(32'h012A4020, 32'h7000);
      chk("ar_after_id", out_id, 0);
      chk("ar_after_count", count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, buffered successor to the 54-instruction combinational decoder.
- Accepts raw 32-bit MIPS instruction words plus their PC over a valid/ready handshake, decodes each to a 6-bit instruction ID with an illegal flag, and extracts the operand fields.
- Buffers decoded entries in a DEPTH-entry FIFO and presents them to the execute stage over a second valid/ready handshake.
- Sits between instruction fetch and execute, and adds back-pressure, flush and illegal-instruction accounting.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- PC_W, 32, width of the PC carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an instruction.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  PC of in_inst.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head entry.
- out_id  out  6  decoded instruction ID; 63 = illegal or empty.
- out_illegal  out  1  head instruction matched no ID.
- out_rs, out_rt, out_rd, out_sa  out  5 each  instruction bits [25:21], [20:16], [15:11], [10:6].
- out_imm  out  16  instruction bits [15:0].
- out_target  out  26  instruction bits [25:0].
- out_pc  out  PC_W  PC of the head entry.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- illegal_cnt  out  8  saturating count of illegal instructions accepted.

Behaviour:
- ID map, given as ID name op/func (hex); an entry with no func matches on op only:
  - 0 ADD 00/20, 1 ADDU 00/21, 2 SUB 00/22, 3 SUBU 00/23, 4 AND 00/24, 5 OR 00/25, 6 XOR 00/26, 7 NOR 00/27, 8 SLT 00/2A, 9 SLTU 00/2B
  - 10 SLL 00/00, 11 SRL 00/02, 12 SRA 00/03, 13 SLLV 00/04, 14 SRLV 00/06, 15 SRAV 00/07, 16 JR 00/08
  - 17 ADDI 08, 18 ADDIU 09, 19 ANDI 0C, 20 ORI 0D, 21 XORI 0E, 22 LW 23, 23 SW 2B, 24 BEQ 04, 25 BNE 05, 26 SLTI 0A, 27 SLTIU 0B, 28 LUI 0F, 29 J 02, 30 JAL 03
  - 31 CLZ 1C/20, 32 DIVU 00/1B, 33 ERET 10/18, 34 JALR 00/09, 35 LB 20, 36 LBU 24, 37 LHU 25, 38 SB 28, 39 SH 29, 40 LH 21
  - 41 MFC0 10/00 with rs=00, 42 MFHI 00/10, 43 MFLO 00/12, 44 MTC0 10/00 with rs=04, 45 MTHI 00/11, 46 MTLO 00/13
  - 47 MUL 1C/02, 48 MULTU 00/19, 49 SYSCALL 00/0C, 50 TEQ 00/34, 51 BGEZ 01, 52 BREAK 00/0D, 53 DIV 00/1A
- Decode: combinational on in_inst. No match gives ID 63 and illegal=1. ID plus fields are written into the FIFO on push.
- Push: in_valid && in_ready && !flush. Pop: out_valid && out_ready && !flush.
- in_ready = (count < DEPTH). No same-cycle bypass when full: in_ready stays 0 at count==DEPTH even if a pop occurs in that cycle.
- Latency: an entry pushed in cycle N appears with out_valid=1 in cycle N+1 if the queue was empty. Output is first-word fall-through from the head entry.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
- Empty outputs: out_valid=0, out_id=63, out_illegal=0, and every field/PC output forced to 0.
- flush: next cycle count=0, both pointers 0, out_valid=0. A push or pop in the flush cycle is ignored. illegal_cnt is not cleared by flush.
- illegal_cnt: increments on each push whose decoded illegal=1. Saturates at 255.
- Reset (asynchronous, any time including mid-transfer):
  - count=0, pointers=0, illegal_cnt=0, in_ready=1, out_valid=0, out_id=63.
  - All other outputs 0.
  - Storage array contents need no reset.

Optional Feature:
- Macro: DECQ_STRICT_EN.
- When defined, reserved fields must also be zero or match, otherwise the result is ID 63 with illegal=1:
  - SLL/SRL/SRA require rs=0.
  - Other op-00 ALU R-types, and SLLV/SRLV/SRAV, require sa=0.
  - JR requires rt=rd=sa=0.
  - ERET requires in_inst==32'h42000018.
  - MFC0/MTC0 require bits [10:3]=0.
  - BGEZ requires rt=01.
  - MFHI/MFLO require rs=rt=sa=0.
  - MTHI/MTLO require rt=rd=sa=0.
- When not defined, only op/func (and rs for MFC0/MTC0) are compared, as in the map.
- 32'h00000000 decodes to SLL in both modes.

Test Plan:
- Reset release, push 32'h012A4020 (ADD) with pc 32'h00400000 -> next cycle out_valid=1, out_id=0, out_rs=9, out_rt=10, out_rd=8, out_pc=32'h00400000.
- out_ready=0, push 5 instructions with DEPTH=4 -> count=4, in_ready=0 after the 4th accept, 5th held off; then pop in order, IDs match push order.
- Push 32'hFC000000 -> out_id=63, out_illegal=1, illegal_cnt=1; 300 illegal pushes -> illegal_cnt=255.
- count=2, flush asserted together with in_valid=1 -> next cycle count=0, out_valid=0, the pushed entry is dropped.
- Push 32'h00221080 (SLL with rs=1) -> out_id=10 without DECQ_STRICT_EN; out_id=63 and illegal=1 with it.
- count=3, assert rst between clock edges -> count=0, out_valid=0, out_id=63 immediately, before the next clock edge.
